rvfi_retire_queue: RTL

Parametrised, in-order retirement queue between the mp4 core's commit stage(s) and the RVFI monitor. Accepts up to `CHANNELS` retired-instruction packets per cycle, oldest on the lowest channel, and replays them to the monitor one per cycle with a monotonically increasing `order` tag. It also provides sticky halt detection (jump-to-self) and overflow detection. It replaces per-signal `assign`-based RVFI hookup once the core retires more than one instruction per cycle.

---
 rtl/rvfi_retire_queue_pkg.sv | 29 ++
 rtl/rvfi_retire_queue_if.sv | 37 +++
 rtl/retire_compact.sv | 25 ++
 rtl/rvfi_retire_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/rvfi_retire_queue_pkg.sv
// Shared types for the RVFI retirement queue.
//   rvfi_pkt_t : one retired instruction as seen by the RVFI monitor
//   RVFI_XLEN  : data/address width used inside rvfi_pkt_t
//   ORDER_W    : width of the rvfi.order tag
package rvfi_retire_queue_pkg;

  localparam int RVFI_XLEN = 32;
  localparam int ORDER_W   = 64;

  typedef struct packed {
    logic [31:0]            inst;
    logic                   trap;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [RVFI_XLEN-1:0]   rs1_rdata;
    logic [RVFI_XLEN-1:0]   rs2_rdata;
    logic                   load_regfile;
    logic [4:0]             rd_addr;
    logic [RVFI_XLEN-1:0]   rd_wdata;
    logic [RVFI_XLEN-1:0]   pc_rdata;
    logic [RVFI_XLEN-1:0]   pc_wdata;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_XLEN/8-1:0] mem_rmask;
    logic [RVFI_XLEN/8-1:0] mem_wmask;
    logic [RVFI_XLEN-1:0]   mem_rdata;
    logic [RVFI_XLEN-1:0]   mem_wdata;
  } rvfi_pkt_t;

endpackage

// File: rtl/rvfi_retire_queue_if.sv
// Bundle between the commit stage (master) and the retirement queue (slave).
//   in_valid / in_pkt : per-channel retire strobes and packets, channel 0 oldest
//   in_ready          : queue can take a full CHANNELS-wide group this cycle
//   out_valid/out_pkt/out_order : head packet presented to the RVFI monitor
//   halt / overflow   : sticky status flags
//
// Handshake: a group is accepted at a rising clock edge when any in_valid bit
// is set and in_ready is 1. in_ready depends only on registered state, never
// on in_valid. If any in_valid bit is set while in_ready is 0 the whole group
// is dropped and overflow latches. The output side has no ready: out_valid=1
// means the head packet is consumed at the next edge.
interface rvfi_retire_queue_if
  import rvfi_retire_queue_pkg::*;
#(
  parameter int CHANNELS = 2
);

  logic [CHANNELS-1:0] in_valid;
  rvfi_pkt_t           in_pkt [CHANNELS];
  logic                in_ready;
  logic                out_valid;
  rvfi_pkt_t           out_pkt;
  logic [ORDER_W-1:0]  out_order;
  logic                halt;
  logic                overflow;

  modport master (
    output in_valid, in_pkt,
    input  in_ready, out_valid, out_pkt, out_order, halt, overflow
  );

  modport slave (
    input  in_valid, in_pkt,
    output in_ready, out_valid, out_pkt, out_order, halt, overflow
  );

endinterface

// File: rtl/retire_compact.sv
// Combinational compaction of the retire strobes.
//   valid    : per-channel retire strobes
//   offset   : for each channel, number of valid channels below it, i.e. the
//              slot offset from the write pointer for that channel's packet
//   popcount : total number of valid channels
module retire_compact #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = $clog2(CHANNELS + 1)
) (
  input  logic [CHANNELS-1:0] valid,
  output logic [CNT_W-1:0]    offset [CHANNELS],
  output logic [CNT_W-1:0]    popcount
);

  always_comb begin : prefix_count
    logic [CNT_W-1:0] run;
    run = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      offset[c] = run;
      run       = run + CNT_W'(valid[c]);
    end
    popcount = run;
  end

endmodule

// File: rtl/rvfi_retire_queue.sv
// In-order retirement queue feeding the RVFI monitor.
// Takes up to CHANNELS retired packets per cycle, stores them in a circular
// buffer and replays them one per cycle with an increasing order tag.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : slave side of rvfi_retire_queue_if (see interface for signals)
// Flags: halt latches after a jump-to-self packet pops; overflow latches on a
// push attempt while in_ready is low.
module rvfi_retire_queue
  import rvfi_retire_queue_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rvfi_retire_queue_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(CHANNELS + 1);

  rvfi_pkt_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   count;
  logic [PTR_W-1:0]   count_next;
  logic [ORDER_W-1:0] order_q;
  logic               halt_q;
  logic               overflow_q;

  logic [CNT_W-1:0]   slot_off [CHANNELS];
  logic [CNT_W-1:0]   push_cnt;
  logic               any_valid;
  logic               ready_raw;
  logic               push_en;
  logic               pop_en;
  logic               jump_self;
  rvfi_pkt_t          head_pkt;

  retire_compact #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W)
  ) u_compact (
    .valid    (bus.in_valid),
    .offset   (slot_off),
    .popcount (push_cnt)
  );

  // Space check uses the registered count only, so a pop in the same cycle
  // does not make room for this cycle's group.
  assign ready_raw = ((PTR_W'(DEPTH) - count) >= PTR_W'(CHANNELS)) && !halt_q;
  assign any_valid = |bus.in_valid;
  assign push_en   = ready_raw && any_valid;
  assign pop_en    = (count != '0);
  assign head_pkt  = mem[rd_ptr[IDX_W-1:0]];

  assign jump_self = pop_en && !head_pkt.trap &&
                     (head_pkt.pc_wdata[XLEN-1:0] == head_pkt.pc_rdata[XLEN-1:0]);

  always_comb begin
    count_next = count;
    if (push_en) count_next = count_next + PTR_W'(push_cnt);
    if (pop_en)  count_next = count_next - PTR_W'(1);
  end

  // Outputs are forced to their idle values while reset is held so the
  // monitor never sees stale entries during a mid-drain reset.
  assign bus.in_ready  = !rst || ready_raw;
  assign bus.out_valid = rst && pop_en;
  assign bus.out_pkt   = (rst && pop_en) ? head_pkt : '0;
  assign bus.out_order = order_q;
  assign bus.halt      = halt_q;
  assign bus.overflow  = overflow_q;

  // Storage carries no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rst && push_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.in_valid[c]) begin
          mem[wr_ptr[IDX_W-1:0] + IDX_W'(slot_off[c])] <= bus.in_pkt[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      order_q    <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      if (pop_en) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        order_q <= order_q + ORDER_W'(1);
      end
      count <= count_next;
      if (jump_self)               halt_q     <= 1'b1;
      if (any_valid && !ready_raw) overflow_q <= 1'b1;
    end
  end

endmodule
